// File: rtl/rca16_structural_adder.sv
// Registered 16-bit structural ripple-carry adder: {cout, sum} = a + b + cin.
// Full-adder cells are built from gate-level expressions, chained in groups of
// GROUP cells, with the groups chained to WIDTH bits. ovf flags signed overflow.
// Optional build macro RCA16_IN_REG_EN: register a/b/cin before the ripple chain
// (latency 2 instead of 1); the port list is unchanged.
module rca16_structural_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NGROUP = WIDTH / GROUP;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

`ifdef RCA16_IN_REG_EN
  // Input capture stage; the adder works on these registered copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
    end else begin
      op_a   <= a;
      op_b   <= b;
      op_cin <= cin;
    end
  end
`else
  // Inputs feed the ripple chain directly.
  assign op_a   = a;
  assign op_b   = b;
  assign op_cin = cin;
`endif

  logic [WIDTH-1:0] s;
  logic             c_msb_in;   // carry into the top bit
  logic             c_out;      // carry out of the top bit
  logic             ovf_n;

  // Ripple chain: each cell and group carries a scalar carry-in/out so the
  // chain is a plain net-to-net path rather than a self-referencing vector.
  for (genvar g = 0; g < int'(NGROUP); g++) begin : g_group
    logic gci;
    logic gco;

    if (g == 0) begin : g_cin_first
      assign gci = op_cin;
    end else begin : g_cin_chain
      assign gci = g_group[g-1].gco;
    end

    for (genvar i = 0; i < int'(GROUP); i++) begin : g_cell
      localparam int BIT = g * int'(GROUP) + i;
      logic ci;
      logic co;
      logic p;

      if (i == 0) begin : g_ci_first
        assign ci = gci;
      end else begin : g_ci_chain
        assign ci = g_cell[i-1].co;
      end

      // Gate-level full adder.
      assign p      = op_a[BIT] ^ op_b[BIT];
      assign s[BIT] = p ^ ci;
      assign co     = (op_a[BIT] & op_b[BIT]) | (ci & p);
    end

    assign gco = g_cell[GROUP-1].co;
  end

  assign c_out    = g_group[NGROUP-1].gco;
  assign c_msb_in = g_group[NGROUP-1].g_cell[GROUP-1].ci;
  assign ovf_n    = c_msb_in ^ c_out;

  // Output register stage, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      sum  <= s;
      cout <= c_out;
      ovf  <= ovf_n;
    end
  end

endmodule

// File: tb/tb_rca16_structural_adder.sv
// Self-checking bench for rca16_structural_adder: reset behaviour, a streamed
// table of hand-computed vectors, and a mid-stream reset pulse.
module tb_rca16_structural_adder;

`ifdef RCA16_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  localparam int NVEC = 11;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int pass_cnt;
  int total_cnt;

  vec_t vecs [NVEC];

  rca16_structural_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] es, input logic ec, input logic eo);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, 16'(cout), 16'(ec));
    chk({tag, ".ovf"}, 16'(ovf), 16'(eo));
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0]  = '{16'hFE01, 16'hFFFF, 1'b1, 16'hFE01, 1'b1, 1'b0};
    vecs[1]  = '{16'hFC03, 16'h3FFF, 1'b0, 16'h3C02, 1'b1, 1'b0};
    vecs[2]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0};
    vecs[5]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[8]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[9]  = '{16'h0001, 16'h7FFF, 1'b1, 16'h8001, 1'b0, 1'b1};
    vecs[10] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};

    // Reset state with non-trivial inputs present.
    rst_n = 1'b0;
    a     = 16'hFF00;
    b     = 16'hFFFF;
    cin   = 1'b1;
    #1;
    chk_out("reset0", 16'h0000, 1'b0, 1'b0);

    // Release; the first result after release reflects the current inputs.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk_out("release", 16'hFF00, 1'b1, 1'b0);

    // Asynchronous assert: outputs clear with no clock edge in between.
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk_out("rst_hold", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk_out("release2", 16'hFF00, 1'b1, 1'b0);

    // Back-to-back stream: one operand set per cycle, checked LAT cycles later.
    for (int i = 0; i < NVEC + LAT; i++) begin
      if (i >= LAT) begin
        chk_out($sformatf("vec%0d", i - LAT), vecs[i-LAT].sum, vecs[i-LAT].cout, vecs[i-LAT].ovf);
      end
      if (i < NVEC) begin
        a   = vecs[i].a;
        b   = vecs[i].b;
        cin = vecs[i].cin;
      end
      @(negedge clk);
    end

    // Reset pulse between edges while AAAA + 5555 + 1 is in flight.
    a   = 16'hAAAA;
    b   = 16'h5555;
    cin = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 16'h0000, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
`ifdef RCA16_IN_REG_EN
    @(posedge clk);
    @(negedge clk);
    chk_out("mid_nostale", 16'h0000, 1'b0, 1'b0);
`endif
    @(posedge clk);
    @(negedge clk);
    chk_out("mid_after", 16'h0000, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
